// File: rtl/rvvi_seq_pkg.sv
// rvvi_seq_pkg: trace record layout and order-checker state shared by the sequencer.
package rvvi_seq_pkg;
  localparam int XLEN = 64;
  localparam int ORDERW = 64;
  typedef struct packed {
    logic [ORDERW-1:0] order;
    logic [31:0]       insn;
    logic [XLEN-1:0]   pc;
    logic              trap;
    logic [1:0]        mode;
  } trace_rec_t;
  localparam int REC_W = $bits(trace_rec_t);
  typedef enum logic {IDLE, TRACK} chk_state_t;
endpackage

// File: rtl/rvvi_trace_sequencer_if.sv
// rvvi_trace_sequencer_if: record handshake, control and multi-retire slot bus.
// Record side: rec_valid/rec_ready/rec_hart/rec_data; control: flush, drain, stall.
// Slot side: out_valid/out_data indexed hart*NRET+slot, sticky order_err per hart.
// Optional RVVI_SEQ_STATS_EN adds ret_count/trap_count (32 bits per hart).
interface rvvi_trace_sequencer_if import rvvi_seq_pkg::*; #(
  parameter int NHART = 1,
  parameter int NRET  = 2
);
  localparam int HW = NHART > 1 ? $clog2(NHART) : 1;
  logic                        rec_valid;
  logic                        rec_ready;
  logic [HW-1:0]               rec_hart;
  trace_rec_t                  rec_data;
  logic                        flush;
  logic                        drain;
  logic                        stall;
  logic [NHART*NRET-1:0]       out_valid;
  logic [NHART*NRET*REC_W-1:0] out_data;
  logic [NHART-1:0]            order_err;
`ifdef RVVI_SEQ_STATS_EN
  logic [NHART*32-1:0]         ret_count;
  logic [NHART*32-1:0]         trap_count;
  modport master (output rec_valid, rec_hart, rec_data, flush, drain, stall,
                  input rec_ready, out_valid, out_data, order_err, ret_count, trap_count);
  modport slave  (input rec_valid, rec_hart, rec_data, flush, drain, stall,
                  output rec_ready, out_valid, out_data, order_err, ret_count, trap_count);
`else
  modport master (output rec_valid, rec_hart, rec_data, flush, drain, stall,
                  input rec_ready, out_valid, out_data, order_err);
  modport slave  (input rec_valid, rec_hart, rec_data, flush, drain, stall,
                  output rec_ready, out_valid, out_data, order_err);
`endif
endinterface

// File: rtl/rvvi_seq_hart_fifo.sv
// rvvi_seq_hart_fifo: one hart's record FIFO with batched multi-pop, age timeout and order checker.
// Inputs: clk, reset_n (async active-low), flush/drain/stall controls, push_i with push_data_i.
// Outputs: full_o, registered slot_valid_o/slot_data_o (NRET slots), sticky order_err_o.
// Optional RVVI_SEQ_STATS_EN adds ret_count_o/trap_count_o.
module rvvi_seq_hart_fifo import rvvi_seq_pkg::*; #(
  parameter int NRET    = 2,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  drain,
  input  logic                  stall,
  input  logic                  push_i,
  input  trace_rec_t            push_data_i,
  output logic                  full_o,
  output logic [NRET-1:0]       slot_valid_o,
  output logic [NRET*REC_W-1:0] slot_data_o,
  output logic                  order_err_o
`ifdef RVVI_SEQ_STATS_EN
  ,
  output logic [31:0]           ret_count_o,
  output logic [31:0]           trap_count_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  trace_rec_t mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d, k;
  logic [TW-1:0] age_q, age_d;
  logic [NRET-1:0] sv_q, sv_d;
  logic [NRET*REC_W-1:0] sd_q, sd_d;
  logic fire;
  chk_state_t st_q;
  logic [ORDERW-1:0] exp_q;
  logic err_q;
  always_comb begin
    fire = !stall && (cnt_q >= CW'(NRET) || (cnt_q != '0 && (drain || age_q == TW'(TIMEOUT-1))));
    k = !fire ? '0 : cnt_q >= CW'(NRET) ? CW'(NRET) : cnt_q;
    sv_d = sv_q;
    sd_d = sd_q;
    for (int s = 0; s < NRET; s++) begin
      if (!stall) begin
        sv_d[s] = CW'(s) < k;
        sd_d[s*REC_W +: REC_W] = CW'(s) < k ? mem_q[rd_q + AW'(s)] : '0;
      end
    end
    // count < NRET whenever a non-empty hart does not fire, so only saturation needs guarding
    age_d = stall ? age_q : (fire || cnt_q == '0) ? '0 : age_q == TW'(TIMEOUT-1) ? age_q : age_q + 1'b1;
    cnt_d = cnt_q + CW'(push_i) - k;
    rd_d = rd_q + AW'(k);
    wr_d = wr_q + AW'(push_i);
    if (flush) begin
      sv_d = '0;
      sd_d = '0;
      age_d = '0;
      cnt_d = '0;
      rd_d = '0;
      wr_d = '0;
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= push_data_i;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      age_q <= '0;
      sv_q <= '0;
      sd_q <= '0;
      st_q <= IDLE;
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      age_q <= age_d;
      sv_q <= sv_d;
      sd_q <= sd_d;
      if (flush) begin
        st_q <= IDLE;
        err_q <= 1'b0;
      end else if (push_i) begin
        err_q <= err_q | (st_q == TRACK && push_data_i.order != exp_q);
        exp_q <= push_data_i.order + 1'b1;
        st_q <= TRACK;
      end
    end
  end
  assign full_o = cnt_q == CW'(DEPTH);
  assign slot_valid_o = sv_q;
  assign slot_data_o = sd_q;
  assign order_err_o = err_q;
`ifdef RVVI_SEQ_STATS_EN
  logic [31:0] ret_q, ret_d, trap_q, trap_d;
  always_comb begin
    trap_d = trap_q;
    for (int s = 0; s < NRET; s++) trap_d = trap_d + 32'(CW'(s) < k && mem_q[rd_q + AW'(s)].trap);
    ret_d = ret_q + 32'(k);
    if (flush) begin
      ret_d = '0;
      trap_d = '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ret_q <= '0;
      trap_q <= '0;
    end else begin
      ret_q <= ret_d;
      trap_q <= trap_d;
    end
  end
  assign ret_count_o = ret_q;
  assign trap_count_o = trap_q;
`endif
endmodule

// File: rtl/rvvi_trace_sequencer.sv
// rvvi_trace_sequencer: per-hart trace record buffering issued as NHART x NRET RVVI retire slots.
// Ports: clk, reset_n (async active-low), bus (rvvi_trace_sequencer_if.slave) carrying
// the record handshake, flush/drain/stall and the slot/order_err outputs.
// Optional RVVI_SEQ_STATS_EN adds per-hart ret_count/trap_count on the bus.
module rvvi_trace_sequencer import rvvi_seq_pkg::*; #(
  parameter int NHART   = 1,
  parameter int NRET    = 2,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4
) (
  input logic clk,
  input logic reset_n,
  rvvi_trace_sequencer_if.slave bus
);
  localparam int HW = NHART > 1 ? $clog2(NHART) : 1;
  // hart codes beyond NHART read as permanently busy so they are never accepted
  logic [2**HW-1:0] busy;
  assign bus.rec_ready = !bus.flush && !busy[bus.rec_hart];
  for (genvar h = 0; h < 2**HW; h++) begin : g_h
    if (h < NHART) begin : g_f
      rvvi_seq_hart_fifo #(.NRET(NRET), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (bus.flush),
        .drain        (bus.drain),
        .stall        (bus.stall),
        .push_i       (bus.rec_valid && bus.rec_ready && bus.rec_hart == HW'(h)),
        .push_data_i  (bus.rec_data),
        .full_o       (busy[h]),
        .slot_valid_o (bus.out_valid[h*NRET +: NRET]),
        .slot_data_o  (bus.out_data[h*NRET*REC_W +: NRET*REC_W]),
        .order_err_o  (bus.order_err[h])
`ifdef RVVI_SEQ_STATS_EN
        ,
        .ret_count_o  (bus.ret_count[h*32 +: 32]),
        .trap_count_o (bus.trap_count[h*32 +: 32])
`endif
      );
    end else begin : g_x
      assign busy[h] = 1'b1;
    end
  end
endmodule

// File: doc/rvvi_trace_sequencer.md
Name: rvvi_trace_sequencer

Overview:
- Buffers per-hart retired-instruction trace records and issues them as multi-retire RVVI slots.
- Records come from the trace-file parser through a valid/ready handshake.
- Generalises the single-hart, single-retire path to NHART harts × NRET retire slots, with batching, timeout flush and order checking.
- Sits between the trace parser and the rvviTrace interface feeding the coverage model.

Parameters:
- XLEN, 64, register/PC width (32 or 64).
- NHART, 1, number of harts (1..4).
- NRET, 2, retire slots per hart per cycle (1..4).
- DEPTH, 8, FIFO entries per hart (power of 2, ≥ NRET).
- TIMEOUT, 4, cycles a partial batch waits before being issued anyway (≥1).
- ORDERW, 64, width of the ORDER field.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- rec_valid  in  1  input record valid.
- rec_ready  out  1  sequencer can accept a record for rec_hart.
- rec_hart  in  max(1,$clog2(NHART))  target hart of the record.
- rec_data  in  REC_W  packed trace_rec_t {order, insn, pc, trap, mode}.
- flush  in  1  synchronous clear of all FIFOs and checker state.
- drain  in  1  issue any partial batch immediately.
- stall  in  1  hold all outputs; no pops.
- out_valid  out  NHART*NRET  slot valid, index hart*NRET+slot.
- out_data  out  NHART*NRET*REC_W  slot payloads, same indexing.
- order_err  out  NHART  sticky per-hart ORDER discontinuity flag.

Behaviour:
- Reset (async, reset_n=0): FIFOs empty, out_valid=0, out_data=0, order_err=0, age counters=0, all checkers in IDLE. rec_ready goes to 1 on the first clk after deassertion.
- Handshake:
  - rec_ready = !flush && count[rec_hart] < DEPTH, using the count before this cycle's pop (no same-cycle bypass when full).
  - A record transfers when rec_valid && rec_ready. rec_data must stay stable while rec_valid && !rec_ready.
  - Out-of-range rec_hart: rec_ready=0.
- Issue decision, per hart, evaluated each cycle with stall=0. Fire when:
  - count ≥ NRET, or
  - count > 0 && (drain || age == TIMEOUT-1).
- Issue action: pop k = min(count, NRET) oldest entries into slots 0..k-1 in FIFO order. out_valid for those slots = 1 on the next edge; remaining slots get 0.
- Non-firing harts, stall=0: out_valid for all their slots = 0 on the next edge.
- Latency: a record accepted at edge N appears at the earliest at edge N+1, when its batch fills, drain is asserted, or the timeout expires.
- Age counter, per hart:
  - Increments each stall=0 cycle while 0 < count < NRET and no issue occurs.
  - Resets to 0 on issue or when count==0.
  - Saturates at TIMEOUT-1.
- Stall=1: out_valid/out_data hold, no pops, age holds, pushes continue.
- Order checker FSM, per hart:
  - IDLE: the first accepted record loads expected = order+1 → TRACK.
  - TRACK: an accepted record with order != expected sets order_err (sticky); expected = order+1 regardless. The record is still accepted.
  - ORDER wraps modulo 2^ORDERW; all-ones → 0 is not an error.
- Flush (synchronous): on the next edge, FIFOs empty, out_valid=0, age=0, order_err=0, checkers → IDLE. rec_ready=0 during flush, so no record is accepted that cycle. Flush overrides drain and stall.
- Simultaneous push and pop on a hart: count' = count + 1 - k. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro RVVI_SEQ_STATS_EN.
- Defined:
  - Adds output ports ret_count (NHART*32, retired records) and trap_count (NHART*32, retired records with trap=1).
  - Counters increment on issue by k and by the popcount of issued traps respectively.
  - Counters wrap at 2^32 and are cleared by reset and flush.
- Undefined: no ports, no counters; all other behaviour identical.

Decomposition:
- Package rvvi_seq_pkg holds:
  - trace_rec_t packed struct (order[ORDERW], insn[32], pc[XLEN], trap, mode[2]).
  - REC_W localparam.
  - Checker state enum {IDLE, TRACK}.
- One sub-module rvvi_seq_hart_fifo: per-hart DEPTH-entry FIFO, multi-pop of up to NRET, with count, age counter and order checker. Instantiated NHART times via generate.

Test Plan:
- NRET=2: push orders 1,2 to hart 0 → edge after 2nd push: out_valid[1:0]=11, slot0.order=1, slot1.order=2.
- Push one record (order 5), drain=0, TIMEOUT=4 → out_valid[0]=1 exactly 4 stall-free cycles after acceptance, slot1 invalid.
- DEPTH=8: fill hart 0 with stall=1 → rec_ready=0 at count 8. Release stall → 2 records/cycle; rec_ready=1 the cycle after the first pop.
- Orders 10,11,13 → order_err[0]=1 after the 3rd push and stays 1. Flush → order_err=0, FIFO empty, next record (any order) accepted without error.
- Order 2^64-1 then 0 → order_err stays 0.
- reset_n pulsed low mid-burst with FIFO count 5 → out_valid=0 immediately, count=0. With RVVI_SEQ_STATS_EN, ret_count=0.
